// File: rtl/aes_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_pkg : byte counts and scheduler state encoding for sbox_sched |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package aes_pkg;

    localparam int ST_BYTES = 16;
    localparam int KW_BYTES = 4;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/Sbox1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Sbox1 : combinational AES forward S-box, one byte in, one byte out|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module Sbox1 (
    input  logic [7:0] state,
    output logic [7:0] Sstate
);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] c_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_idx;

    assign w_idx  = {~state, 3'b000};
    assign Sstate = c_SBOX_TABLE[w_idx +: 8];

endmodule
`default_nettype wire

// File: rtl/sbox_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sbox_sched : one shared S-box serving SubBytes and SubWord jobs   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sbox_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_start,
    input  logic [127:0] st_in,
    output logic [127:0] st_out,
    output logic         st_done,
    input  logic         kw_start,
    input  logic [31:0]  kw_in,
    output logic [31:0]  kw_out,
    output logic         kw_done,
    output logic         busy
);

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       work_q, res_q;
    logic               st_pend_q, kw_pend_q;
    logic [127:0]       st_pend_data_q;
    logic [31:0]        kw_pend_data_q;
    logic [127:0]       st_out_q;
    logic [31:0]        kw_out_q;
    logic               st_done_q, kw_done_q;

    logic [CNT_W+2:0]   w_bit;
    logic [7:0]         w_sb_in, w_sb_out;
    logic [127:0]       w_res_next;
    logic               w_acc_kw, w_acc_st, w_last;

    // SubWord operands live in the top word so both jobs share byte indexing.
    assign w_bit   = {~cnt_q, 3'b000};
    assign w_sb_in = work_q[w_bit +: 8];

    Sbox1 u_sbox (
        .state  (w_sb_in),
        .Sstate (w_sb_out)
    );

    always_comb begin
        w_res_next             = res_q;
        w_res_next[w_bit +: 8] = w_sb_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        w_acc_kw = 1'b0;
        w_acc_st = 1'b0;
        w_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (kw_start || kw_pend_q) begin
                    w_acc_kw = 1'b1;
                    state_d  = KW_RUN;
                end else if (st_start || st_pend_q) begin
                    w_acc_st = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: if (cnt_q == CNT_W'(ST_BYTES - 1)) begin
                w_last  = 1'b1;
                state_d = IDLE;
            end
            KW_RUN: if (cnt_q == CNT_W'(KW_BYTES - 1)) begin
                w_last  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            work_q         <= '0;
            res_q          <= '0;
            st_pend_q      <= 1'b0;
            kw_pend_q      <= 1'b0;
            st_pend_data_q <= '0;
            kw_pend_data_q <= '0;
            st_out_q       <= '0;
            kw_out_q       <= '0;
            st_done_q      <= 1'b0;
            kw_done_q      <= 1'b0;
        end else begin
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
            if (w_acc_kw) begin
                work_q    <= {(kw_start ? kw_in : kw_pend_data_q), 96'h0};
                cnt_q     <= '0;
                kw_pend_q <= 1'b0;
            end else if (w_acc_st) begin
                work_q    <= st_start ? st_in : st_pend_data_q;
                cnt_q     <= '0;
                st_pend_q <= 1'b0;
            end else if (state_q != IDLE) begin
                res_q <= w_res_next;
                cnt_q <= cnt_q + CNT_W'(1);
                if (w_last && state_q == ST_RUN) begin
                    st_out_q  <= w_res_next;
                    st_done_q <= 1'b1;
                end
                if (w_last && state_q == KW_RUN) begin
                    kw_out_q  <= w_res_next[127:96];
                    kw_done_q <= 1'b1;
                end
            end
            // Any start not accepted this edge pends; a repeat overwrites the operand.
            if (st_start && !w_acc_st) begin
                st_pend_q      <= 1'b1;
                st_pend_data_q <= st_in;
            end
            if (kw_start && !w_acc_kw) begin
                kw_pend_q      <= 1'b1;
                kw_pend_data_q <= kw_in;
            end
        end
    end

    assign st_out  = st_out_q;
    assign kw_out  = kw_out_q;
    assign st_done = st_done_q;
    assign kw_done = kw_done_q;
    assign busy    = (state_q != IDLE) || st_pend_q || kw_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sbox_sched : directed vectors and corner sequences, sbox_sched |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_sbox_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_start = 1'b0;
    logic [127:0] st_in = '0;
    logic [127:0] st_out;
    logic         st_done;
    logic         kw_start = 1'b0;
    logic [31:0]  kw_in = '0;
    logic [31:0]  kw_out;
    logic         kw_done;
    logic         busy;

    int errors = 0;
    int checks = 0;

    sbox_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_start (st_start),
        .st_in    (st_in),
        .st_out   (st_out),
        .st_done  (st_done),
        .kw_start (kw_start),
        .kw_in    (kw_in),
        .kw_out   (kw_out),
        .kw_done  (kw_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_kw;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] c_ST_A   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] c_ST_A_X = 128'hd42711aee0bf98f1b8b45de51e415230;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (st_done && kw_done) begin
            errors++;
            $display("FAIL both_done: st_done=%b kw_done=%b expected not both high", st_done, kw_done);
        end
    end

    task automatic run_job(input bit is_kw, input logic [127:0] din, output int lat);
        @(negedge clk);
        if (is_kw) begin kw_start = 1'b1; kw_in = din[31:0]; end
        else       begin st_start = 1'b1; st_in = din; end
        @(negedge clk);
        kw_start = 1'b0;
        st_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (is_kw ? kw_done : st_done) lat = c;
        end
    endtask

    vec_t         vecs [6];
    logic [127:0] last_st, last_kw, cap0, cap1;
    int           lat, st_at, kw_at, st_at2, n_st, n_done;
    bit           bad;

    initial begin
        vecs[0] = '{1'b0, c_ST_A, c_ST_A_X};
        vecs[1] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01};
        vecs[2] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                          128'h637c777bf26b6fc53001672bfed7ab76};
        vecs[3] = '{1'b1, 128'h00112233, 128'h638293c3};
        vecs[4] = '{1'b0, {16{8'hff}}, {16{8'h16}}};
        vecs[5] = '{1'b1, 128'h53535353, 128'hedededed};
        last_st = '0;
        last_kw = '0;

        repeat (2) @(negedge clk);
        chk("reset_st_out", st_out, '0);
        chk("reset_kw_out", {96'h0, kw_out}, '0);
        chk("reset_flags", {125'h0, st_done, kw_done, busy}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].is_kw, vecs[i].din, lat);
            if (vecs[i].is_kw) begin
                chk($sformatf("vec%0d_kw_out", i), {96'h0, kw_out}, vecs[i].exp);
                chk($sformatf("vec%0d_kw_lat", i), 128'(lat), 128'd4);
                chk($sformatf("vec%0d_st_hold", i), st_out, last_st);
                last_kw = vecs[i].exp;
            end else begin
                chk($sformatf("vec%0d_st_out", i), st_out, vecs[i].exp);
                chk($sformatf("vec%0d_st_lat", i), 128'(lat), 128'd16);
                chk($sformatf("vec%0d_kw_hold", i), {96'h0, kw_out}, last_kw);
                last_st = vecs[i].exp;
            end
            chk($sformatf("vec%0d_busy_end", i), {127'h0, busy}, '0);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse_width", i), {126'h0, st_done, kw_done}, '0);
        end

        // Simultaneous starts: kw first, then one idle cycle, then st.
        @(negedge clk);
        st_start = 1'b1; st_in = c_ST_A;
        kw_start = 1'b1; kw_in = 32'hcf4f3c09;
        st_at = -1; kw_at = -1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 0) begin st_start = 1'b0; kw_start = 1'b0; end
            if (kw_done && kw_at < 0) begin kw_at = c; cap1 = {96'h0, kw_out}; end
            if (st_done && st_at < 0) begin st_at = c; cap0 = st_out; end
        end
        chk("simul_kw_lat", 128'(kw_at), 128'd4);
        chk("simul_st_lat", 128'(st_at), 128'd21);
        chk("simul_kw_out", cap1, 128'h8a84eb01);
        chk("simul_st_out", cap0, c_ST_A_X);

        // kw start during ST cycle 5 pends until ST completes.
        @(negedge clk);
        st_start = 1'b1; st_in = c_ST_A;
        st_at = -1; kw_at = -1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 0) st_start = 1'b0;
            if (c == 5) begin kw_start = 1'b1; kw_in = 32'h01010a4f; end
            if (c == 6) kw_start = 1'b0;
            if (kw_done && kw_at < 0) begin kw_at = c; cap1 = {96'h0, kw_out}; end
            if (st_done && st_at < 0) begin st_at = c; cap0 = st_out; end
        end
        chk("mid_st_lat", 128'(st_at), 128'd16);
        chk("mid_st_out", cap0, c_ST_A_X);
        chk("mid_kw_lat", 128'(kw_at), 128'd21);
        chk("mid_kw_out", cap1, 128'h7c7c6784);

        // Two st starts while busy: only the latest operand runs, once.
        @(negedge clk);
        st_start = 1'b1; st_in = c_ST_A;
        st_at = -1; st_at2 = -1; n_st = 0;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (c == 0) st_start = 1'b0;
            if (c == 3) begin st_start = 1'b1; st_in = {16{8'hff}}; end
            if (c == 4) st_start = 1'b0;
            if (c == 6) begin st_start = 1'b1; st_in = '0; end
            if (c == 7) st_start = 1'b0;
            if (st_done) begin
                n_st++;
                if (st_at < 0) begin st_at = c; cap0 = st_out; end
                else if (st_at2 < 0) begin st_at2 = c; cap1 = st_out; end
            end
        end
        chk("dup_first_lat", 128'(st_at), 128'd16);
        chk("dup_first_out", cap0, c_ST_A_X);
        chk("dup_second_lat", 128'(st_at2), 128'd33);
        chk("dup_second_out", cap1, {16{8'h63}});
        chk("dup_job_count", 128'(n_st), 128'd2);
        chk("dup_busy_end", {127'h0, busy}, '0);

        // Reset during ST cycle 8 aborts the job without a done pulse.
        @(negedge clk);
        st_start = 1'b1; st_in = c_ST_A;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) st_start = 1'b0;
        end
        kw_start = 1'b1; kw_in = 32'h01010a4f;
        @(negedge clk);
        kw_start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_st_out", st_out, '0);
        chk("rst_kw_out", {96'h0, kw_out}, '0);
        chk("rst_flags", {125'h0, st_done, kw_done, busy}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (st_done || kw_done || busy) bad = 1'b1;
        end
        chk("rst_quiet_after_release", {127'h0, bad}, '0);
        run_job(1'b1, 128'hcf4f3c09, lat);
        chk("rst_new_kw_out", {96'h0, kw_out}, 128'h8a84eb01);
        chk("rst_new_kw_lat", 128'(lat), 128'd4);
        chk("rst_st_still_zero", st_out, '0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports and parameters are listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 st_start  input  1  SubBytes request; sampled on rising edge.
REQ-005 st_in  input  128  SubBytes state; byte 0 = [127:120], byte 15 = [7:0].
REQ-006 st_out  output  128  registered SubBytes result, same byte order.
REQ-007 st_done  output  1  one-cycle pulse when st_out is updated.
REQ-008 kw_start  input  1  SubWord request (key schedule); sampled on rising edge.
REQ-009 kw_in  input  32  word to substitute; byte 0 = [31:24].
REQ-010 kw_out  output  32  registered SubWord result.
REQ-011 kw_done  output  1  one-cycle pulse when kw_out is updated.
REQ-012 busy  output  1  high when state != IDLE or any request is pending.
REQ-013 Parameters: none; byte counts come from the package.

Function
REQ-014 A single S-box instance SHALL be time-shared, substituting exactly one byte per clock.
REQ-015 FSM states: IDLE, ST_RUN, KW_RUN.
REQ-016 IDLE: kw request (live or pending) -> KW_RUN; otherwise st request (live or pending) -> ST_RUN; otherwise stay.
REQ-017 On acceptance: the operand SHALL be captured into the work register, the byte counter cleared, and the matching pending flag cleared.
REQ-018 RUN: each edge SHALL write sbox(work byte[cnt]) into result byte[cnt] and increment cnt.
REQ-019 The edge that processes the last byte (cnt 15 for ST, 3 for KW) SHALL:
  - copy the result into st_out or kw_out;
  - pulse the matching done for exactly one cycle;
  - return the FSM to IDLE.
REQ-020 Latency: if the start edge is T, st_done SHALL be high in the cycle after edge T+16, and kw_done in the cycle after edge T+4.
REQ-021 From IDLE after a completion, a pending request SHALL be accepted on the next edge, giving exactly one idle cycle between jobs.
REQ-022 A start that arrives while busy, or that loses arbitration, SHALL set a one-deep pending flag and latch its operand.
REQ-023 A start on a requester that already has a pending request SHALL overwrite the latched operand; the job runs once.
REQ-024 A start on the requester currently running SHALL pend, and SHALL NOT corrupt the job in flight.
REQ-025 Simultaneous st_start and kw_start in IDLE: kw runs first, st pends.
REQ-026 st_out and kw_out SHALL hold their value until the next completion of the same requester.
REQ-027 st_done and kw_done SHALL never be high in the same cycle.

Reset
REQ-028 While rst_n = 0, the block SHALL hold: FSM IDLE; cnt 0; pending flags 0; st_out 0; kw_out 0; st_done 0; kw_done 0; busy 0.
REQ-029 Reset mid-operation SHALL abort the job and drop all pending requests, with no done pulse; after release the block idles until the next start.

Structure
REQ-030 Package aes_pkg SHALL hold ST_BYTES = 16, KW_BYTES = 4, and the FSM state encoding typedef.
REQ-031 The existing combinational S-box module Sbox1 (ports state, Sstate) SHALL be instantiated exactly once; no other sub-module.

Verification
REQ-032 Single ST job: st_in = 193de3bea0f4e22b9ac68d2ae9f84808 -> st_out = d42711aee0bf98f1b8b45de51e415230, st_done 16 cycles after start.
REQ-033 Single KW job: kw_in = cf4f3c09 -> kw_out = 8a84eb01, kw_done 4 cycles after start.
REQ-034 Simultaneous starts (operands as in REQ-032 and REQ-033) -> kw_done first; st_done follows one idle cycle plus 16 cycles later; both results correct.
REQ-035 kw_start with kw_in = 01010a4f at ST cycle 5 -> ST completes unchanged, then kw_out = 7c7c6784.
REQ-036 rst_n low during ST cycle 8 -> all outputs 0, no done pulse, busy 0; a new job after release completes correctly.
REQ-037 Two st_starts while busy (second st_in = all 00) -> one ST job runs, st_out = all 63.
